// File: rtl/fft_mem_pkg.sv
// Shared types and constants for the parametrised FFT data-memory RAM.
package fft_mem_pkg;

  // Result of a same-port read issued together with a write.
  typedef enum logic {
    RDW_READ_FIRST,
    RDW_WRITE_FIRST
  } rdw_mode_e;

  // Clear sequencer states.
  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_e;

  // Read latency in cycles for each OUT_REG setting.
  localparam int OUT_REG_LAT_0 = 1;
  localparam int OUT_REG_LAT_1 = 2;

  function automatic int read_latency(input bit out_reg);
    return out_reg ? OUT_REG_LAT_1 : OUT_REG_LAT_0;
  endfunction

endpackage

// File: rtl/dp_ram_param_if.sv
// Bus bundle for both RAM ports plus the clear/collision side-band signals.
interface dp_ram_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);

  logic              i_clr;
  logic              o_busy;
  logic [ADDR_W-1:0] i_addr_a;
  logic [DATA_W-1:0] i_data_a;
  logic              i_we_a;
  logic              i_re_a;
  logic [DATA_W-1:0] o_data_a;
  logic              o_valid_a;
  logic [ADDR_W-1:0] i_addr_b;
  logic [DATA_W-1:0] i_data_b;
  logic              i_we_b;
  logic              i_re_b;
  logic [DATA_W-1:0] o_data_b;
  logic              o_valid_b;
  logic              o_collision;

  // Requester side (butterfly / address generator).
  modport master (
    output i_clr, i_addr_a, i_data_a, i_we_a, i_re_a,
           i_addr_b, i_data_b, i_we_b, i_re_b,
    input  o_busy, o_data_a, o_valid_a, o_data_b, o_valid_b, o_collision
  );

  // Memory side.
  modport slave (
    input  i_clr, i_addr_a, i_data_a, i_we_a, i_re_a,
           i_addr_b, i_data_b, i_we_b, i_re_b,
    output o_busy, o_data_a, o_valid_a, o_data_b, o_valid_b, o_collision
  );

endinterface

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps the lower half through port A and the upper half
// through port B in parallel, so the whole array clears in DEPTH/2 cycles.
module ram_clear_seq
  import fft_mem_pkg::*;
#(
  parameter int                DEPTH     = 1024,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0,
  localparam int               ADDR_W    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  output logic              o_busy,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [ADDR_W-1:0] o_addr_b,
  output logic [DATA_W-1:0] o_data
);

  localparam int              PTR_W    = ADDR_W - 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH / 2 - 1);

  clr_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // State and sweep pointer registers; reset aborts any sweep in progress.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (i_rst) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: a clear request starts the sweep, the last pointer ends it.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLR_IDLE: begin
        if (i_clr) begin
          state_d = CLR_RUN;
          ptr_d   = '0;
        end
      end
      CLR_RUN: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = CLR_IDLE;
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign o_busy   = (state_q == CLR_RUN);
  assign o_we     = o_busy;
  assign o_addr_a = {1'b0, ptr_q};
  assign o_addr_b = {1'b1, ptr_q};
  assign o_data   = CLR_VALUE;

endmodule

// File: rtl/dp_ram_param.sv
// Parametrised true dual-port RAM for FFT sample storage: per-port read
// enables with valid strobes, selectable same-port read-during-write,
// optional output register, port-A-wins collision handling and clear sweep.
module dp_ram_param
  import fft_mem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  localparam int               ADDR_W    = $clog2(DEPTH),
  parameter bit                OUT_REG   = 1'b0,
  parameter rdw_mode_e         RDW_MODE  = RDW_READ_FIRST,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0,
  parameter string             INIT_FILE = ""
) (
  input logic          i_clk,
  input logic          i_rst,
  dp_ram_param_if.slave bus
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_busy, clr_we;
  logic [ADDR_W-1:0] clr_addr_a, clr_addr_b;
  logic [DATA_W-1:0] clr_data;

  logic              re_a, re_b, usr_we_a, usr_we_b, collide;
  logic              we_a, we_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;

  logic [DATA_W-1:0] s1_data_a_q, s1_data_a_d, s1_data_b_q, s1_data_b_d;
  logic              s1_valid_a_q, s1_valid_a_d, s1_valid_b_q, s1_valid_b_d;
  logic              coll_q, coll_d;

  ram_clear_seq #(
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .CLR_VALUE (CLR_VALUE)
  ) u_clr_seq (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (bus.i_clr),
    .o_busy   (clr_busy),
    .o_we     (clr_we),
    .o_addr_a (clr_addr_a),
    .o_addr_b (clr_addr_b),
    .o_data   (clr_data)
  );

  // Port muxes: the sweep owns both write ports while busy; user requests
  // are dropped then. On a same-address dual write port B yields to port A.
  always_comb begin
    re_a     = bus.i_re_a & ~clr_busy;
    re_b     = bus.i_re_b & ~clr_busy;
    usr_we_a = bus.i_we_a & ~clr_busy;
    usr_we_b = bus.i_we_b & ~clr_busy;
    collide  = usr_we_a & usr_we_b & (bus.i_addr_a == bus.i_addr_b);
    if (clr_busy) begin
      we_a    = clr_we;
      we_b    = clr_we;
      addr_a  = clr_addr_a;
      addr_b  = clr_addr_b;
      wdata_a = clr_data;
      wdata_b = clr_data;
    end else begin
      we_a    = usr_we_a;
      we_b    = usr_we_b & ~collide;
      addr_a  = bus.i_addr_a;
      addr_b  = bus.i_addr_b;
      wdata_a = bus.i_data_a;
      wdata_b = bus.i_data_b;
    end
  end

  // Array write ports.
  always_ff @(posedge i_clk) begin
    // NOTE: the array itself has no reset; only pipeline and control flops do.
    if (we_a) mem[addr_a] <= wdata_a;
    if (we_b) mem[addr_b] <= wdata_b;
  end

  // First read stage: the array read sees pre-edge contents, which gives
  // old data cross-port in both modes; write-first bypasses own write data.
  always_comb begin
    s1_data_a_d  = s1_data_a_q;
    s1_data_b_d  = s1_data_b_q;
    s1_valid_a_d = re_a;
    s1_valid_b_d = re_b;
    coll_d       = collide;
    if (re_a) begin
      s1_data_a_d = (RDW_MODE == RDW_WRITE_FIRST && usr_we_a) ? bus.i_data_a
                                                              : mem[bus.i_addr_a];
    end
    if (re_b) begin
      s1_data_b_d = (RDW_MODE == RDW_WRITE_FIRST && usr_we_b) ? bus.i_data_b
                                                              : mem[bus.i_addr_b];
    end
  end

  // First-stage read registers and the collision flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_data_a_q  <= '0;
      s1_data_b_q  <= '0;
      s1_valid_a_q <= 1'b0;
      s1_valid_b_q <= 1'b0;
      coll_q       <= 1'b0;
    end else begin
      s1_data_a_q  <= s1_data_a_d;
      s1_data_b_q  <= s1_data_b_d;
      s1_valid_a_q <= s1_valid_a_d;
      s1_valid_b_q <= s1_valid_b_d;
      coll_q       <= coll_d;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [DATA_W-1:0] s2_data_a_q, s2_data_a_d, s2_data_b_q, s2_data_b_d;
    logic              s2_valid_a_q, s2_valid_b_q;

    // Output stage loads only on a valid first-stage word so data holds.
    always_comb begin
      s2_data_a_d = s1_valid_a_q ? s1_data_a_q : s2_data_a_q;
      s2_data_b_d = s1_valid_b_q ? s1_data_b_q : s2_data_b_q;
    end

    // Output pipeline registers.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        s2_data_a_q  <= '0;
        s2_data_b_q  <= '0;
        s2_valid_a_q <= 1'b0;
        s2_valid_b_q <= 1'b0;
      end else begin
        s2_data_a_q  <= s2_data_a_d;
        s2_data_b_q  <= s2_data_b_d;
        s2_valid_a_q <= s1_valid_a_q;
        s2_valid_b_q <= s1_valid_b_q;
      end
    end

    assign bus.o_data_a  = s2_data_a_q;
    assign bus.o_data_b  = s2_data_b_q;
    assign bus.o_valid_a = s2_valid_a_q;
    assign bus.o_valid_b = s2_valid_b_q;
  end else begin : g_no_out_reg
    assign bus.o_data_a  = s1_data_a_q;
    assign bus.o_data_b  = s1_data_b_q;
    assign bus.o_valid_a = s1_valid_a_q;
    assign bus.o_valid_b = s1_valid_b_q;
  end

  assign bus.o_busy      = clr_busy;
  assign bus.o_collision = coll_q;

endmodule
